// File: rtl/cpu_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and constants for the CPU step sequencer:
//               phase encodings, PC step, stall limit default and the
//               latched decode-flag bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_DECODE = 3'd2,
        PH_EXEC   = 3'd3,
        PH_MEM    = 3'd4,
        PH_WB     = 3'd5,
        PH_PCUPD  = 3'd6,
        PH_HALT   = 3'd7
    } phase_e;

    localparam int unsigned PC_STEP       = 4;
    localparam int unsigned MAX_STALL_DEF = 200;

    // Decode information held from DECODE until the instruction retires.
    typedef struct packed {
        logic load;
        logic store;
        logic rd_write;
        logic halt;
    } dec_flags_t;

endpackage
`default_nettype wire

// File: rtl/cpu_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_sequencer_if
// Description : Handshake and strobe bundle between the step sequencer and
//               the rest of the CPU. The slave modport is the sequencer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_step_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              i_imem_valid;
    logic              i_dmem_stall;
    logic              i_is_load;
    logic              i_is_store;
    logic              i_rd_write;
    logic              i_is_halt;
    logic              i_branch_taken;
    logic [ADDR_W-1:0] i_branch_target;
    logic [ADDR_W-1:0] o_pc;
    logic              o_pc_valid;
    logic              o_imem_req;
    logic              o_dmem_ren;
    logic              o_dmem_wen;
    logic              o_rf_we;
    logic [2:0]        o_phase;
    logic              o_finish;
    logic              o_error;

    modport master (
        output i_imem_valid, i_dmem_stall, i_is_load, i_is_store, i_rd_write,
               i_is_halt, i_branch_taken, i_branch_target,
        input  o_pc, o_pc_valid, o_imem_req, o_dmem_ren, o_dmem_wen, o_rf_we,
               o_phase, o_finish, o_error
    );

    modport slave (
        input  i_imem_valid, i_dmem_stall, i_is_load, i_is_store, i_rd_write,
               i_is_halt, i_branch_taken, i_branch_target,
        output o_pc, o_pc_valid, o_imem_req, o_dmem_ren, o_dmem_wen, o_rf_we,
               o_phase, o_finish, o_error
    );
endinterface
`default_nettype wire

// File: rtl/cpu_step_sequencer_stall_timer.sv
`default_nettype none
// ============================================================================
// Module      : stall_timer
// Description : Saturating wait counter. o_expired flags the cycle in which
//               the LIMIT-th consecutive stalled cycle is being spent.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_timer #(
    parameter int TMO_W = 8,
    parameter int LIMIT = 200
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expired
);
    localparam logic [TMO_W-1:0] c_LAST = TMO_W'(LIMIT - 1);

    logic [TMO_W-1:0] r_count;

    // Count stalled cycles; cleared whenever the owner phase is not active.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en && !o_expired)
            r_count <= r_count + TMO_W'(1);
    end

    assign o_expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_sequencer
// Description : Multi-cycle instruction sequencer. Walks each instruction
//               through FETCH/DECODE/EXEC/MEM/WB/PCUPD, owns the PC and
//               stops on halt, misaligned branch target or stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int TMO_W     = 8,
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    cpu_step_sequencer_if.slave  bus
);
    localparam logic [2:0] c_ST_IDLE   = PH_IDLE;
    localparam logic [2:0] c_ST_FETCH  = PH_FETCH;
    localparam logic [2:0] c_ST_DECODE = PH_DECODE;
    localparam logic [2:0] c_ST_EXEC   = PH_EXEC;
    localparam logic [2:0] c_ST_MEM    = PH_MEM;
    localparam logic [2:0] c_ST_WB     = PH_WB;
    localparam logic [2:0] c_ST_PCUPD  = PH_PCUPD;
    localparam logic [2:0] c_ST_HALT   = PH_HALT;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              w_err_set;
    dec_flags_t        r_flags;
    logic              r_br_taken;
    logic [ADDR_W-1:0] r_br_target;
    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;
    logic              r_error;
    logic              w_expired;
    logic              w_misaligned;

    // A taken branch to a non-word address is a fatal fault at PC update.
    assign w_misaligned = r_br_taken && (r_br_target[1:0] != 2'b00);

    stall_timer #(
        .TMO_W (TMO_W),
        .LIMIT (MAX_STALL)
    ) u_stall_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     ((r_state != c_ST_FETCH) && (r_state != c_ST_MEM)),
        .i_en      (((r_state == c_ST_FETCH) && !bus.i_imem_valid) ||
                    ((r_state == c_ST_MEM)   &&  bus.i_dmem_stall)),
        .o_expired (w_expired)
    );

    // Next-phase selection; a completed handshake takes priority over timeout.
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_next = c_ST_FETCH;
            c_ST_FETCH: begin
                if (bus.i_imem_valid) begin
                    w_next = c_ST_DECODE;
                end else if (w_expired) begin
                    w_next    = c_ST_HALT;
                    w_err_set = 1'b1;
                end
            end
            c_ST_DECODE: w_next = c_ST_EXEC;
            c_ST_EXEC:   w_next = (r_flags.load || r_flags.store) ? c_ST_MEM : c_ST_WB;
            c_ST_MEM: begin
                if (!bus.i_dmem_stall) begin
                    w_next = c_ST_WB;
                end else if (w_expired) begin
                    w_next    = c_ST_HALT;
                    w_err_set = 1'b1;
                end
            end
            c_ST_WB:     w_next = c_ST_PCUPD;
            c_ST_PCUPD: begin
                if (w_misaligned) begin
                    w_next    = c_ST_HALT;
                    w_err_set = 1'b1;
                end else if (r_flags.halt) begin
                    w_next = c_ST_HALT;
                end else begin
                    w_next = c_ST_FETCH;
                end
            end
            c_ST_HALT:   w_next = c_ST_HALT;
            default:     w_next = c_ST_HALT;
        endcase
    end

    // Phase register plus the sticky error flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_err_set)
                r_error <= 1'b1;
        end
    end

    // Capture decode flags at the end of DECODE and branch info at end of EXEC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags     <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            if (r_state == c_ST_DECODE) begin
                r_flags.load     <= bus.i_is_load;
                r_flags.store    <= bus.i_is_store;
                r_flags.rd_write <= bus.i_rd_write;
                r_flags.halt     <= bus.i_is_halt;
            end
            if (r_state == c_ST_EXEC) begin
                r_br_taken  <= bus.i_branch_taken;
                r_br_target <= bus.i_branch_target;
            end
        end
    end

    // PC update at the end of PCUPD; valid pulse is seen alongside the new PC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc       <= '0;
            r_pc_valid <= 1'b0;
        end else if ((r_state == c_ST_PCUPD) && !w_misaligned) begin
            r_pc       <= r_br_taken ? r_br_target : (r_pc + ADDR_W'(PC_STEP));
            r_pc_valid <= 1'b1;
        end else begin
            r_pc_valid <= 1'b0;
        end
    end

    // Strobes decode straight from the phase so a reset kills them at once.
    assign bus.o_imem_req = (r_state == c_ST_FETCH);
    assign bus.o_dmem_ren = (r_state == c_ST_MEM) && r_flags.load;
    assign bus.o_dmem_wen = (r_state == c_ST_MEM) && r_flags.store && !r_flags.load;
    assign bus.o_rf_we    = (r_state == c_ST_WB) && r_flags.rd_write;
    assign bus.o_pc       = r_pc;
    assign bus.o_pc_valid = r_pc_valid;
    assign bus.o_phase    = r_state;
    assign bus.o_finish   = (r_state == c_ST_HALT);
    assign bus.o_error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_step_sequencer
// Description : Directed self-checking bench for cpu_step_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_sequencer;

    localparam int ADDR_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    cpu_step_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    cpu_step_sequencer #(
        .ADDR_W    (ADDR_W),
        .TMO_W     (8),
        .MAX_STALL (200)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_inputs();
        bus.i_imem_valid    = 1'b0;
        bus.i_dmem_stall    = 1'b0;
        bus.i_is_load       = 1'b0;
        bus.i_is_store      = 1'b0;
        bus.i_rd_write      = 1'b0;
        bus.i_is_halt       = 1'b0;
        bus.i_branch_taken  = 1'b0;
        bus.i_branch_target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.o_phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", bus.o_phase); end
        n_checks++;
        if (bus.o_pc !== 64'd0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", bus.o_pc); end
        n_checks++;
        if ({bus.o_imem_req, bus.o_dmem_ren, bus.o_dmem_wen, bus.o_rf_we, bus.o_pc_valid, bus.o_finish, bus.o_error} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000",
                {bus.o_imem_req, bus.o_dmem_ren, bus.o_dmem_wen, bus.o_rf_we, bus.o_pc_valid, bus.o_finish, bus.o_error});
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [2:0] exp_ph [6];
        int we_cnt;
        exp_ph = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd1};
        we_cnt = 0;
        do_reset();
        bus.i_imem_valid = 1'b1;
        bus.i_rd_write   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (bus.o_phase !== exp_ph[i]) begin n_fail++; $display("FAIL alu_phase[%0d]: got %0d want %0d", i, bus.o_phase, exp_ph[i]); end
            if (bus.o_rf_we === 1'b1) we_cnt++;
            if (i == 0) begin
                n_checks++;
                if (bus.o_imem_req !== 1'b1) begin n_fail++; $display("FAIL alu_imem_req: got %b want 1", bus.o_imem_req); end
            end
            if (i == 4) begin
                n_checks++;
                if (bus.o_pc !== 64'd0 || bus.o_pc_valid !== 1'b0) begin
                    n_fail++; $display("FAIL alu_pcupd: pc %0h valid %b want 0/0", bus.o_pc, bus.o_pc_valid);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (bus.o_pc !== 64'd4 || bus.o_pc_valid !== 1'b1) begin
                    n_fail++; $display("FAIL alu_pc_next: pc %0h valid %b want 4/1", bus.o_pc, bus.o_pc_valid);
                end
            end
        end
        n_checks++;
        if (we_cnt != 1) begin n_fail++; $display("FAIL alu_rf_we_count: got %0d want 1", we_cnt); end
        step();
        n_checks++;
        if (bus.o_pc_valid !== 1'b0) begin n_fail++; $display("FAIL alu_pc_valid_pulse: got %b want 0", bus.o_pc_valid); end
    endtask

    task automatic test_load_stall();
        int mem_bad;
        mem_bad = 0;
        do_reset();
        bus.i_imem_valid = 1'b1;
        bus.i_is_load    = 1'b1;
        bus.i_rd_write   = 1'b1;
        bus.i_dmem_stall = 1'b1;
        run_steps(3);
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.o_phase !== 3'd4 || bus.o_dmem_ren !== 1'b1 || bus.o_dmem_wen !== 1'b0 || bus.o_rf_we !== 1'b0) mem_bad++;
            if (k == 3) bus.i_dmem_stall = 1'b0;
        end
        n_checks++;
        if (mem_bad != 0) begin n_fail++; $display("FAIL load_mem_cycles: %0d bad MEM cycles want 0", mem_bad); end
        step();
        n_checks++;
        if (bus.o_phase !== 3'd5 || bus.o_rf_we !== 1'b1 || bus.o_dmem_ren !== 1'b0) begin
            n_fail++; $display("FAIL load_wb: phase %0d rf_we %b ren %b want 5/1/0", bus.o_phase, bus.o_rf_we, bus.o_dmem_ren);
        end
        step();
        n_checks++;
        if (bus.o_phase !== 3'd6 || bus.o_rf_we !== 1'b0) begin
            n_fail++; $display("FAIL load_after_wb: phase %0d rf_we %b want 6/0", bus.o_phase, bus.o_rf_we);
        end
    endtask

    task automatic test_load_store_both();
        do_reset();
        bus.i_imem_valid = 1'b1;
        bus.i_is_load    = 1'b1;
        bus.i_is_store   = 1'b1;
        run_steps(4);
        n_checks++;
        if (bus.o_phase !== 3'd4 || bus.o_dmem_ren !== 1'b1 || bus.o_dmem_wen !== 1'b0) begin
            n_fail++; $display("FAIL ld_st_both: phase %0d ren %b wen %b want 4/1/0", bus.o_phase, bus.o_dmem_ren, bus.o_dmem_wen);
        end
    endtask

    task automatic test_branch();
        do_reset();
        bus.i_imem_valid = 1'b1;
        run_steps(11);
        n_checks++;
        if (bus.o_pc !== 64'h8 || bus.o_phase !== 3'd1) begin
            n_fail++; $display("FAIL br_setup: pc %0h phase %0d want 8/1", bus.o_pc, bus.o_phase);
        end
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 64'h100;
        run_steps(4);
        n_checks++;
        if (bus.o_phase !== 3'd6 || bus.o_pc !== 64'h8) begin
            n_fail++; $display("FAIL br_pcupd: phase %0d pc %0h want 6/8", bus.o_phase, bus.o_pc);
        end
        step();
        n_checks++;
        if (bus.o_pc !== 64'h100 || bus.o_pc_valid !== 1'b1 || bus.o_phase !== 3'd1) begin
            n_fail++; $display("FAIL br_taken: pc %0h valid %b phase %0d want 100/1/1", bus.o_pc, bus.o_pc_valid, bus.o_phase);
        end

        do_reset();
        bus.i_imem_valid = 1'b1;
        run_steps(11);
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 64'h102;
        run_steps(5);
        n_checks++;
        if (bus.o_phase !== 3'd7 || bus.o_pc !== 64'h8 || bus.o_finish !== 1'b1 ||
            bus.o_error !== 1'b1 || bus.o_pc_valid !== 1'b0) begin
            n_fail++; $display("FAIL br_misaligned: phase %0d pc %0h fin %b err %b valid %b want 7/8/1/1/0",
                bus.o_phase, bus.o_pc, bus.o_finish, bus.o_error, bus.o_pc_valid);
        end
    endtask

    task automatic test_fetch_timeout();
        int pcv_seen;
        pcv_seen = 0;
        do_reset();
        run_steps(1);
        for (int k = 2; k <= 200; k++) begin
            step();
            if (bus.o_pc_valid === 1'b1) pcv_seen++;
        end
        n_checks++;
        if (bus.o_phase !== 3'd1 || bus.o_error !== 1'b0) begin
            n_fail++; $display("FAIL tmo_before: phase %0d err %b want 1/0", bus.o_phase, bus.o_error);
        end
        step();
        if (bus.o_pc_valid === 1'b1) pcv_seen++;
        n_checks++;
        if (bus.o_phase !== 3'd7 || bus.o_error !== 1'b1 || bus.o_finish !== 1'b1 || bus.o_imem_req !== 1'b0) begin
            n_fail++; $display("FAIL tmo_halt: phase %0d err %b fin %b req %b want 7/1/1/0",
                bus.o_phase, bus.o_error, bus.o_finish, bus.o_imem_req);
        end
        n_checks++;
        if (pcv_seen != 0) begin n_fail++; $display("FAIL tmo_pc_valid: got %0d pulses want 0", pcv_seen); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_phase !== 3'd0 || bus.o_pc !== 64'd0 || bus.o_error !== 1'b0 || bus.o_finish !== 1'b0) begin
            n_fail++; $display("FAIL tmo_reset: phase %0d pc %0h err %b fin %b want 0/0/0/0",
                bus.o_phase, bus.o_pc, bus.o_error, bus.o_finish);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_halt_branch();
        int unstable;
        unstable = 0;
        do_reset();
        bus.i_imem_valid    = 1'b1;
        bus.i_is_halt       = 1'b1;
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 64'h40;
        run_steps(6);
        n_checks++;
        if (bus.o_phase !== 3'd7 || bus.o_pc !== 64'h40 || bus.o_pc_valid !== 1'b1 ||
            bus.o_finish !== 1'b1 || bus.o_error !== 1'b0) begin
            n_fail++; $display("FAIL halt_entry: phase %0d pc %0h valid %b fin %b err %b want 7/40/1/1/0",
                bus.o_phase, bus.o_pc, bus.o_pc_valid, bus.o_finish, bus.o_error);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.o_pc !== 64'h40 || bus.o_phase !== 3'd7 || bus.o_pc_valid !== 1'b0 ||
                bus.o_imem_req !== 1'b0 || bus.o_rf_we !== 1'b0) unstable++;
        end
        n_checks++;
        if (unstable != 0) begin n_fail++; $display("FAIL halt_stable: %0d unstable cycles want 0", unstable); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        bus.i_imem_valid    = 1'b1;
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        run_steps(6);
        n_checks++;
        if (bus.o_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: pc %0h want fffffffffffffffc", bus.o_pc); end
        bus.i_branch_taken = 1'b0;
        run_steps(5);
        n_checks++;
        if (bus.o_pc !== 64'd0 || bus.o_pc_valid !== 1'b1 || bus.o_phase !== 3'd1) begin
            n_fail++; $display("FAIL wrap_pc: pc %0h valid %b phase %0d want 0/1/1", bus.o_pc, bus.o_pc_valid, bus.o_phase);
        end
    endtask

    task automatic test_reset_in_mem();
        do_reset();
        bus.i_imem_valid = 1'b1;
        bus.i_is_store   = 1'b1;
        bus.i_dmem_stall = 1'b1;
        run_steps(4);
        n_checks++;
        if (bus.o_phase !== 3'd4 || bus.o_dmem_wen !== 1'b1 || bus.o_dmem_ren !== 1'b0) begin
            n_fail++; $display("FAIL store_mem: phase %0d wen %b ren %b want 4/1/0", bus.o_phase, bus.o_dmem_wen, bus.o_dmem_ren);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_dmem_wen !== 1'b0 || bus.o_phase !== 3'd0) begin
            n_fail++; $display("FAIL rst_in_mem: wen %b phase %0d want 0/0", bus.o_dmem_wen, bus.o_phase);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu();
        test_load_stall();
        test_load_store_both();
        test_branch();
        test_fetch_timeout();
        test_halt_branch();
        test_pc_wrap();
        test_reset_in_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
